// File: rtl/ex_stage_pkg.sv
// Shared constants and types for the EX stage: funct codes, FSM states,
// multiply/divide operation select and default widths.
package ex_stage_pkg;

    localparam int DW_DEF   = 32;
    localparam int ITER_DEF = 32;

    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_e;
    typedef enum logic {MD_MULTU, MD_DIVU} md_op_e;

    // True for the funct codes handled by the iterative unit.
    function automatic logic is_muldiv(input logic [5:0] f);
        return (f == F_MULTU) || (f == F_DIVU);
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle. master = upstream/downstream pipeline,
// slave = the EX stage itself.
interface ex_stage_if import ex_stage_pkg::*; #(parameter int DW = DW_DEF);

    logic          in_valid_EX;
    logic [DW-1:0] data1_EX;
    logic [DW-1:0] data2_EX;
    logic [31:0]   funct_EX;
    logic [4:0]    rd_EX;
    logic [4:0]    rt_EX;
    logic          regdst_EX;
    logic [7:0]    nextins_EX;

    logic          stall_EX;
    logic          out_valid_EX;
    logic [DW-1:0] result_EX;
    logic [4:0]    wreg_EX;
    logic          wen_EX;
    logic [7:0]    nextins_out_EX;
    logic          illegal_EX;

    modport master (
        output in_valid_EX, data1_EX, data2_EX, funct_EX, rd_EX, rt_EX,
               regdst_EX, nextins_EX,
        input  stall_EX, out_valid_EX, result_EX, wreg_EX, wen_EX,
               nextins_out_EX, illegal_EX
    );

    modport slave (
        input  in_valid_EX, data1_EX, data2_EX, funct_EX, rd_EX, rt_EX,
               regdst_EX, nextins_EX,
        output stall_EX, out_valid_EX, result_EX, wreg_EX, wen_EX,
               nextins_out_EX, illegal_EX
    );

endinterface

// File: rtl/ex_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide. The first
// iteration is performed on the start edge using the incoming operands, so
// the unit needs ITER-1 further cycles; done flags the cycle of the last one.
// result = {HI, LO}: product, or {remainder, quotient}.
module ex_muldiv import ex_stage_pkg::*; #(
    parameter int DW   = DW_DEF,
    parameter int ITER = ITER_DEF
) (
    input  logic          clk_EX,
    input  logic          rstn_EX,
    input  logic          start,
    input  md_op_e        op,
    input  logic [DW-1:0] op_a,
    input  logic [DW-1:0] op_b,
    output logic          done,
    output logic [2*DW-1:0] result
);
    localparam int CW = $clog2(ITER) + 1;

    logic [2*DW-1:0] acc_q, acc_d, acc_cur, acc_nxt;
    logic [DW-1:0]   opnd_q, opnd_d, opnd_cur;
    md_op_e          op_q, op_d, op_cur;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic [DW:0]     sum, shifted, diff;
    logic            geq;

    // One iteration on either the freshly loaded operands or the running state.
    always_comb begin
        if (start) begin
            op_cur   = op;
            opnd_cur = (op == MD_MULTU) ? op_a : op_b;
            acc_cur  = (op == MD_MULTU) ? {{DW{1'b0}}, op_b} : {{DW{1'b0}}, op_a};
        end else begin
            op_cur   = op_q;
            opnd_cur = opnd_q;
            acc_cur  = acc_q;
        end
        sum     = {1'b0, acc_cur[2*DW-1:DW]} + (acc_cur[0] ? {1'b0, opnd_cur} : '0);
        shifted = {acc_cur[2*DW-1:DW], acc_cur[DW-1]};
        diff    = shifted - {1'b0, opnd_cur};
        geq     = shifted >= {1'b0, opnd_cur};
        if (op_cur == MD_MULTU)
            acc_nxt = {sum, acc_cur[DW-1:1]};
        else
            acc_nxt = {geq ? diff[DW-1:0] : shifted[DW-1:0], acc_cur[DW-2:0], geq};
    end

    // Iteration sequencing.
    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        op_d   = op_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            acc_d  = acc_nxt;
            opnd_d = opnd_cur;
            op_d   = op_cur;
            cnt_d  = CW'(1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d = acc_nxt;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(ITER - 1))
                busy_d = 1'b0;
        end
    end

    assign done   = busy_q && (cnt_q == CW'(ITER - 1));
    assign result = acc_q;

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk_EX) begin
        if (!rstn_EX) begin
            acc_q  <= '0;
            opnd_q <= '0;
            op_q   <= MD_MULTU;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// EX stage: single-cycle ALU plus HI/LO register pair fed by the iterative
// multiply/divide unit.
//   state   | meaning
//   IDLE    | accepting instructions; ALU ops complete in one cycle
//   MUL     | MULTU iterating, pipeline stalled
//   DIV     | DIVU iterating, pipeline stalled
//   DONE    | commit {HI,LO}, pulse out_valid with wen=0
module ex_stage import ex_stage_pkg::*; #(
    parameter int DW   = DW_DEF,
    parameter int ITER = ITER_DEF
) (
    input logic       clk_EX,
    input logic       rstn_EX,
    ex_stage_if.slave bus
);
    state_e          state_q, state_d;
    logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [DW-1:0]   result_q, result_d;
    logic [4:0]      wreg_q, wreg_d;
    logic [7:0]      nextins_q, nextins_d;
    logic            out_valid_q, out_valid_d;
    logic            wen_q, wen_d;
    logic            illegal_q, illegal_d;
    logic [5:0]      funct;
    logic            start_md;
    logic            md_done;
    logic [2*DW-1:0] md_result;
    md_op_e          md_op;
    logic            unused_funct_hi;

    assign funct           = bus.funct_EX[5:0];
    assign unused_funct_hi = ^bus.funct_EX[31:6];
    assign start_md        = (state_q == ST_IDLE) && bus.in_valid_EX && is_muldiv(funct);
    assign md_op           = (funct == F_DIVU) ? MD_DIVU : MD_MULTU;

    ex_muldiv #(.DW(DW), .ITER(ITER)) u_muldiv (
        .clk_EX  (clk_EX),
        .rstn_EX (rstn_EX),
        .start   (start_md),
        .op      (md_op),
        .op_a    (bus.data1_EX),
        .op_b    (bus.data2_EX),
        .done    (md_done),
        .result  (md_result)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        result_d    = result_q;
        wreg_d      = wreg_q;
        nextins_d   = nextins_q;
        out_valid_d = 1'b0;
        wen_d       = 1'b0;
        illegal_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid_EX) begin
                    wreg_d      = bus.regdst_EX ? bus.rd_EX : bus.rt_EX;
                    nextins_d   = bus.nextins_EX;
                    out_valid_d = 1'b1;
                    wen_d       = 1'b1;
                    case (funct)
                        F_ADD:  result_d = bus.data1_EX + bus.data2_EX;
                        F_SUB:  result_d = bus.data1_EX - bus.data2_EX;
                        F_AND:  result_d = bus.data1_EX & bus.data2_EX;
                        F_OR:   result_d = bus.data1_EX | bus.data2_EX;
                        F_NOR:  result_d = ~(bus.data1_EX | bus.data2_EX);
                        F_SLT:  result_d = {{(DW-1){1'b0}},
                                            $signed(bus.data1_EX) < $signed(bus.data2_EX)};
                        F_MFHI: result_d = hi_q;
                        F_MFLO: result_d = lo_q;
                        F_MULTU: begin
                            state_d     = ST_MUL;
                            out_valid_d = 1'b0;
                            wen_d       = 1'b0;
                        end
                        F_DIVU: begin
                            state_d     = ST_DIV;
                            out_valid_d = 1'b0;
                            wen_d       = 1'b0;
                        end
                        default: begin
                            wen_d     = 1'b0;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                if (md_done)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                {hi_d, lo_d} = md_result;
                out_valid_d  = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, HI/LO and registered outputs.
    always_ff @(posedge clk_EX) begin
        if (!rstn_EX) begin
            state_q     <= ST_IDLE;
            hi_q        <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            wreg_q      <= '0;
            nextins_q   <= '0;
            out_valid_q <= 1'b0;
            wen_q       <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            result_q    <= result_d;
            wreg_q      <= wreg_d;
            nextins_q   <= nextins_d;
            out_valid_q <= out_valid_d;
            wen_q       <= wen_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.stall_EX       = (state_q != ST_IDLE) || start_md;
    assign bus.out_valid_EX   = out_valid_q;
    assign bus.result_EX      = result_q;
    assign bus.wreg_EX        = wreg_q;
    assign bus.wen_EX         = wen_q;
    assign bus.nextins_out_EX = nextins_q;
    assign bus.illegal_EX     = illegal_q;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed corner cases followed by a randomized
// instruction stream, checked against an arithmetic reference model.
module tb_ex_stage;
    import ex_stage_pkg::*;

    localparam int W   = 32;
    localparam int NIT = 32;

    logic clk_EX = 1'b0;
    logic rstn_EX;

    ex_stage_if #(.DW(W)) bus_if();

    ex_stage #(.DW(W), .ITER(NIT)) dut (
        .clk_EX  (clk_EX),
        .rstn_EX (rstn_EX),
        .bus     (bus_if)
    );

    always #5 clk_EX = ~clk_EX;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state.
    logic [31:0] m_hi, m_lo, m_result;
    logic [4:0]  m_wreg;
    logic [7:0]  m_ni;

    logic [5:0] alu_ops [8] = '{F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT, F_MFHI, F_MFLO};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_EX);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [4:0] rt, input logic rdst, input logic [7:0] ni);
        bus_if.in_valid_EX = v;
        bus_if.funct_EX    = {26'($urandom()), f};
        bus_if.data1_EX    = a;
        bus_if.data2_EX    = b;
        bus_if.rd_EX       = rd;
        bus_if.rt_EX       = rt;
        bus_if.regdst_EX   = rdst;
        bus_if.nextins_EX  = ni;
    endtask

    function automatic logic is_alu(input logic [5:0] f);
        foreach (alu_ops[i]) if (alu_ops[i] == f) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            F_ADD:   return a + b;
            F_SUB:   return a - b;
            F_AND:   return a & b;
            F_OR:    return a | b;
            F_NOR:   return ~(a | b);
            F_SLT:   return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            F_MFHI:  return m_hi;
            F_MFLO:  return m_lo;
            default: return m_result;
        endcase
    endfunction

    // Single-cycle instruction (ALU, MFHI/MFLO or unsupported funct).
    task automatic op_single(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input logic [4:0] rt, input logic rdst,
                             input logic [7:0] ni, input string tag);
        logic sup;
        drive(1'b1, f, a, b, rd, rt, rdst, ni);
        #1 chk({tag, ".stall"}, bus_if.stall_EX, 64'd0);
        sup = is_alu(f);
        if (sup) m_result = ref_alu(f, a, b);
        m_wreg = rdst ? rd : rt;
        m_ni   = ni;
        step();
        chk({tag, ".out_valid"}, bus_if.out_valid_EX, 64'd1);
        chk({tag, ".wen"},       bus_if.wen_EX, 64'(sup));
        chk({tag, ".illegal"},   bus_if.illegal_EX, 64'(!sup));
        chk({tag, ".result"},    bus_if.result_EX, 64'(m_result));
        chk({tag, ".wreg"},      bus_if.wreg_EX, 64'(m_wreg));
        chk({tag, ".nextins"},   bus_if.nextins_out_EX, 64'(m_ni));
        bus_if.in_valid_EX = 1'b0;
    endtask

    task automatic op_rand(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
        op_single(f, a, b, 5'($urandom()), 5'($urandom()), 1'($urandom()), 8'($urandom()), tag);
    endtask

    // MULTU / DIVU: counts stall cycles, injects ignored traffic while busy.
    task automatic op_md(input logic isdiv, input logic [31:0] a, input logic [31:0] b, input string tag);
        int n;
        logic [63:0] exp;
        logic [4:0] rd, rt;
        logic rdst;
        logic [7:0] ni;
        rd = 5'($urandom()); rt = 5'($urandom()); rdst = 1'($urandom()); ni = 8'($urandom());
        drive(1'b1, isdiv ? F_DIVU : F_MULTU, a, b, rd, rt, rdst, ni);
        #1 chk({tag, ".stall_accept"}, bus_if.stall_EX, 64'd1);
        m_wreg = rdst ? rd : rt;
        m_ni   = ni;
        if (isdiv) exp = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
        else       exp = {32'd0, a} * {32'd0, b};
        n = 1;
        step();
        while (bus_if.stall_EX === 1'b1 && n < 200) begin
            n++;
            if (n < 6) drive(1'b1, alu_ops[$urandom_range(0, 5)], $urandom(), $urandom(),
                             5'($urandom()), 5'($urandom()), 1'($urandom()), 8'($urandom()));
            else bus_if.in_valid_EX = 1'b0;
            step();
        end
        chk({tag, ".stall_cycles"}, 64'(n), 64'(NIT + 1));
        chk({tag, ".out_valid"},    bus_if.out_valid_EX, 64'd1);
        chk({tag, ".wen"},          bus_if.wen_EX, 64'd0);
        chk({tag, ".illegal"},      bus_if.illegal_EX, 64'd0);
        chk({tag, ".result_held"},  bus_if.result_EX, 64'(m_result));
        chk({tag, ".wreg"},         bus_if.wreg_EX, 64'(m_wreg));
        chk({tag, ".nextins"},      bus_if.nextins_out_EX, 64'(m_ni));
        {m_hi, m_lo} = exp;
    endtask

    task automatic idle(input string tag);
        drive(1'b0, 6'($urandom()), $urandom(), $urandom(), 5'($urandom()), 5'($urandom()),
              1'($urandom()), 8'($urandom()));
        #1 chk({tag, ".stall"}, bus_if.stall_EX, 64'd0);
        step();
        chk({tag, ".out_valid"}, bus_if.out_valid_EX, 64'd0);
        chk({tag, ".wen"},       bus_if.wen_EX, 64'd0);
        chk({tag, ".illegal"},   bus_if.illegal_EX, 64'd0);
        chk({tag, ".result"},    bus_if.result_EX, 64'(m_result));
        chk({tag, ".wreg"},      bus_if.wreg_EX, 64'(m_wreg));
        chk({tag, ".nextins"},   bus_if.nextins_out_EX, 64'(m_ni));
    endtask

    function automatic logic [5:0] pick_illegal();
        logic [5:0] f;
        f = 6'h3F;
        for (int k = 0; k < 100; k++) begin
            f = 6'($urandom());
            if (!is_alu(f) && !is_muldiv(f)) return f;
        end
        return 6'h3F;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        logic [31:0] a, b;

        rstn_EX = 1'b0;
        drive(1'b0, 6'h00, '0, '0, '0, '0, 1'b0, '0);
        m_hi = '0; m_lo = '0; m_result = '0; m_wreg = '0; m_ni = '0;
        step();
        step();
        chk("reset.stall",     bus_if.stall_EX, 64'd0);
        chk("reset.out_valid", bus_if.out_valid_EX, 64'd0);
        chk("reset.wen",       bus_if.wen_EX, 64'd0);
        chk("reset.illegal",   bus_if.illegal_EX, 64'd0);
        chk("reset.result",    bus_if.result_EX, 64'd0);
        chk("reset.wreg",      bus_if.wreg_EX, 64'd0);
        chk("reset.nextins",   bus_if.nextins_out_EX, 64'd0);
        rstn_EX = 1'b1;
        step();

        // Directed corner cases.
        op_single(F_ADD, 32'h7FFF_FFFF, 32'd1, 5'd5, 5'd9, 1'b1, 8'h44, "add_wrap");
        chk("add_wrap.abs_result", bus_if.result_EX, 64'h8000_0000);
        op_rand(F_SLT, 32'hFFFF_FFFF, 32'd1, "slt_neg");
        chk("slt_neg.abs_result", bus_if.result_EX, 64'd1);
        op_rand(F_SUB, 32'd3, 32'd5, "sub_neg");
        chk("sub_neg.abs_result", bus_if.result_EX, 64'hFFFF_FFFE);
        idle("idle0");

        op_md(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        op_rand(F_MFHI, $urandom(), $urandom(), "mfhi_max");
        chk("mfhi_max.abs", bus_if.result_EX, 64'hFFFF_FFFE);
        op_rand(F_MFLO, $urandom(), $urandom(), "mflo_max");
        chk("mflo_max.abs", bus_if.result_EX, 64'h1);

        op_md(1'b1, 32'd100, 32'd7, "divu_100_7");
        op_rand(F_MFLO, $urandom(), $urandom(), "divu_100_7.lo");
        chk("divu_100_7.lo_abs", bus_if.result_EX, 64'd14);
        op_rand(F_MFHI, $urandom(), $urandom(), "divu_100_7.hi");
        chk("divu_100_7.hi_abs", bus_if.result_EX, 64'd2);

        op_md(1'b1, 32'd5, 32'd0, "divu_by0");
        op_rand(F_MFLO, $urandom(), $urandom(), "divu_by0.lo");
        chk("divu_by0.lo_abs", bus_if.result_EX, 64'hFFFF_FFFF);
        op_rand(F_MFHI, $urandom(), $urandom(), "divu_by0.hi");
        chk("divu_by0.hi_abs", bus_if.result_EX, 64'd5);

        op_rand(6'h3F, $urandom(), $urandom(), "illegal_3f");
        op_rand(F_ADD, $urandom(), $urandom(), "add_after_illegal");
        op_rand(F_MFHI, $urandom(), $urandom(), "hi_after_illegal");

        // Reset in the middle of a MULTU.
        drive(1'b1, F_MULTU, $urandom(), $urandom(), 5'd1, 5'd2, 1'b1, 8'h11);
        step();
        bus_if.in_valid_EX = 1'b0;
        repeat (9) step();
        chk("midreset.busy", bus_if.stall_EX, 64'd1);
        rstn_EX = 1'b0;
        step();
        chk("midreset.stall",     bus_if.stall_EX, 64'd0);
        chk("midreset.out_valid", bus_if.out_valid_EX, 64'd0);
        chk("midreset.result",    bus_if.result_EX, 64'd0);
        m_hi = '0; m_lo = '0; m_result = '0; m_wreg = '0; m_ni = '0;
        rstn_EX = 1'b1;
        op_rand(F_MFHI, $urandom(), $urandom(), "midreset.hi");
        op_rand(F_MFLO, $urandom(), $urandom(), "midreset.lo");
        op_rand(F_ADD, $urandom(), $urandom(), "midreset.add");

        // Randomized instruction stream.
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            a = $urandom();
            b = $urandom();
            if (sel <= 6)      op_rand(alu_ops[$urandom_range(0, 7)], a, b, "rnd_alu");
            else if (sel == 7) op_rand(pick_illegal(), a, b, "rnd_illegal");
            else if (sel == 8) idle("rnd_idle");
            else begin
                if ($urandom_range(0, 3) == 0) b = '0;
                else if ($urandom_range(0, 1) == 0) b = 32'($urandom_range(1, 1000));
                op_md(1'($urandom()), a, b, "rnd_md");
                op_rand(F_MFHI, $urandom(), $urandom(), "rnd_md.hi");
                op_rand(F_MFLO, $urandom(), $urandom(), "rnd_md.lo");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
